// File: rtl/jedro_1_defines.sv
// Shared types and constants for the jedro_1 data-bus arbiter slice.
// Defines the request bundle, the arbiter state encoding and the port count.
package jedro_1_defines;
  localparam int DATA_WIDTH = 32;
  localparam int ARB_PORTS  = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            strobe;
    logic                  write;
  } bus_req_t;

  typedef enum logic {
    eIDLE = 1'b0,
    eLOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/jedro_1_id_fifo.sv
// In-order FIFO of 1-bit requester IDs; the head names the owner of the next response.
// Pointers carry one extra wrap bit; the full flag is registered, empty is combinational.
module jedro_1_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_q_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_full;
  logic        r_mem [DEPTH];
  logic [AW:0] w_wr_next;
  logic [AW:0] w_rd_next;
  logic        w_push;
  logic        w_pop;

  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_q_o  = r_full;
  assign head_o    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push    = push_i && !r_full;
  assign w_pop     = pop_i && !empty_o;
  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Full is computed from the next-state pointers so it is valid the cycle after a push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_full   <= (w_wr_next[AW] != w_rd_next[AW]) &&
                  (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= id_i;
  end
endmodule

// File: rtl/jedro_1_bus_arbiter.sv
// Two-port round-robin arbiter for the data-RAM bus (port 0 = LSU, port 1 = fetch/debug).
// Grant is frozen while a request stalls; responses are steered by an in-order owner FIFO.
module jedro_1_bus_arbiter
  import jedro_1_defines::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [ARB_PORTS-1:0]                 s_req_valid_i,
  output logic [ARB_PORTS-1:0]                 s_req_ready_o,
  input  logic [ARB_PORTS-1:0][DATA_WIDTH-1:0] s_req_addr_i,
  input  logic [ARB_PORTS-1:0][DATA_WIDTH-1:0] s_req_data_i,
  input  logic [ARB_PORTS-1:0][3:0]            s_req_strobe_i,
  input  logic [ARB_PORTS-1:0]                 s_req_write_i,
  output logic [DATA_WIDTH-1:0]                s_rsp_data_o,
  output logic                                 s_rsp_error_o,
  output logic [ARB_PORTS-1:0]                 s_rsp_valid_o,
  input  logic [ARB_PORTS-1:0]                 s_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                m_req_addr_o,
  output logic [DATA_WIDTH-1:0]                m_req_data_o,
  output logic [3:0]                           m_req_strobe_o,
  output logic                                 m_req_write_o,
  output logic                                 m_req_valid_o,
  input  logic                                 m_req_ready_i,
  input  logic [DATA_WIDTH-1:0]                m_rsp_data_i,
  input  logic                                 m_rsp_error_i,
  input  logic                                 m_rsp_valid_i,
  output logic                                 m_rsp_ready_o,
  output logic                                 ghost_rsp_o
);
  arb_state_e r_state;
  logic       r_locked_id;
  logic       r_last_grant;

  bus_req_t   w_req [ARB_PORTS];
  bus_req_t   w_sel;
  logic       w_grant_vld;
  logic       w_grant_id;
  logic       w_req_ok;
  logic       w_req_fire;
  logic       w_rsp_ok;
  logic       w_pop;
  logic       w_head;
  logic       w_full_q;
  logic       w_empty;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (r_state == eLOCK) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_locked_id;
    end else if (&s_req_valid_i) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_last_grant;
    end else if (s_req_valid_i[0]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (s_req_valid_i[1]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end
  end

  // A registered full flag blocks the grant even in a cycle that also pops.
  assign w_req_ok       = w_grant_vld && !w_full_q && !rst_i;
  assign w_sel          = w_req[w_grant_id];
  assign m_req_valid_o  = w_req_ok && s_req_valid_i[w_grant_id];
  assign m_req_addr_o   = w_sel.addr;
  assign m_req_data_o   = w_sel.data;
  assign m_req_strobe_o = w_sel.strobe;
  assign m_req_write_o  = w_sel.write;
  assign w_req_fire     = m_req_valid_o && m_req_ready_i;

  assign w_rsp_ok       = !w_empty && !rst_i;
  assign m_rsp_ready_o  = s_rsp_ready_i[w_head] && w_rsp_ok;
  assign w_pop          = m_rsp_valid_i && m_rsp_ready_o;
  assign ghost_rsp_o    = m_rsp_valid_i && w_empty && !rst_i;
  assign s_rsp_data_o   = m_rsp_data_i;
  assign s_rsp_error_o  = m_rsp_error_i;

  for (genvar gi = 0; gi < ARB_PORTS; gi++) begin : g_port
    assign w_req[gi] = '{addr:   s_req_addr_i[gi],
                         data:   s_req_data_i[gi],
                         strobe: s_req_strobe_i[gi],
                         write:  s_req_write_i[gi]};
    assign s_req_ready_o[gi] = m_req_ready_i && w_req_ok && (w_grant_id == 1'(gi));
    assign s_rsp_valid_o[gi] = m_rsp_valid_i && w_rsp_ok && (w_head == 1'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= eIDLE;
      r_locked_id  <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_req_fire) r_last_grant <= w_grant_id;
      case (r_state)
        eIDLE: if (m_req_valid_o && !m_req_ready_i) begin
          r_state     <= eLOCK;
          r_locked_id <= w_grant_id;
        end
        eLOCK: if (w_req_fire) r_state <= eIDLE;
        default: r_state <= eIDLE;
      endcase
    end
  end

  jedro_1_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_fire),
    .id_i    (w_grant_id),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_q_o(w_full_q),
    .empty_o (w_empty)
  );
endmodule
